// File: rtl/gb_interrupt_ctrl.sv
// rtl/gb_interrupt_ctrl.sv - SM83 interrupt controller: IF/IE/IME, priority arbitration, req/ack dispatch, HALT wake
module gb_interrupt_ctrl #(
  parameter logic [15:0] IF_ADDR = 16'hFF0F,
  parameter logic [15:0] IE_ADDR = 16'hFFFF,
  parameter int          NUM_SRC = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_SRC-1:0]  src_pulse,
  input  logic [15:0]         bus_addr,
  input  logic [7:0]          bus_wdata,
  input  logic                bus_we,
  input  logic                bus_re,
  output logic [7:0]          bus_rdata,
  output logic                bus_hit,
  input  logic                ei_pulse,
  input  logic                di_pulse,
  input  logic                reti_pulse,
  input  logic                instr_done,
  output logic                irq_req,
  input  logic                irq_ack,
  output logic [15:0]         irq_vector,
  output logic                irq_vec_valid,
  output logic                wake,
  output logic                ime
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_VEC  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_SRC-1:0]   if_q, if_d;
  logic [7:0]           ie_q, ie_d;
  logic                 ime_q, ime_d;
  logic                 ime_pend_q, ime_pend_d;
  logic [7:0]           rdata_q, rdata_d;
  logic                 hit_q, hit_d;
  logic [15:0]          vector_q, vector_d;

  logic [NUM_SRC-1:0]   pending;
  logic [NUM_SRC-1:0]   if_clr;
  logic [NUM_SRC-1:0]   if_set;
  logic [2:0]           k_idx;
  logic                 k_found;
  logic                 ack_take;
  logic                 wr_if;
  logic                 wr_ie;

  assign pending       = if_q & ie_q[NUM_SRC-1:0];
  assign wake          = |pending;
  assign ime           = ime_q;
  assign irq_req       = (state_q == ST_REQ);
  assign irq_vec_valid = (state_q == ST_VEC);
  assign irq_vector    = vector_q;
  assign bus_rdata     = rdata_q;
  assign bus_hit       = hit_q;

  // Next-state for registers, IME sequencing and the dispatch FSM
  always_comb begin
    state_d    = state_q;
    if_d       = if_q;
    ie_d       = ie_q;
    ime_d      = ime_q;
    ime_pend_d = ime_pend_q;
    rdata_d    = 8'h00;
    hit_d      = 1'b0;
    vector_d   = 16'h0000;
    if_clr     = '0;
    if_set     = '0;
    k_idx      = 3'd0;
    k_found    = 1'b0;
    ack_take   = 1'b0;
    wr_if      = bus_we && (bus_addr == IF_ADDR);
    wr_ie      = bus_we && (bus_addr == IE_ADDR);

    // Lowest set bit wins; scanning downward leaves the lowest index last
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (pending[i]) begin
        k_idx   = 3'(i);
        k_found = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (ime_q && (|pending)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (!ime_q) begin
          state_d = ST_IDLE;
        end else if (irq_ack) begin
          ack_take = 1'b1;
          state_d  = ST_VEC;
          if (k_found) begin
            vector_d = 16'h0040 + {10'd0, k_idx, 3'b000};
            if_clr   = NUM_SRC'(1) << k_idx;
          end
        end
      end
      ST_VEC: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A CPU write replaces IF; the incoming pulse is OR-ed in last so a set always wins
    if (wr_if) begin
      if_clr = if_clr | ~bus_wdata[NUM_SRC-1:0];
      if_set = bus_wdata[NUM_SRC-1:0];
    end
    if_d = (if_q & ~if_clr) | if_set | src_pulse;

    if (wr_ie) ie_d = bus_wdata;

    // IME: delayed EI, immediate RETI, dispatch clears, DI overrides everything
    if (ime_pend_q && instr_done) begin
      ime_d      = 1'b1;
      ime_pend_d = 1'b0;
    end
    if (ei_pulse)   ime_pend_d = 1'b1;
    if (reti_pulse) ime_d      = 1'b1;
    if (ack_take)   ime_d      = 1'b0;
    if (di_pulse) begin
      ime_d      = 1'b0;
      ime_pend_d = 1'b0;
    end

    if (bus_re && (bus_addr == IF_ADDR)) begin
      rdata_d = {{(8 - NUM_SRC){1'b1}}, if_q};
      hit_d   = 1'b1;
    end else if (bus_re && (bus_addr == IE_ADDR)) begin
      rdata_d = ie_q;
      hit_d   = 1'b1;
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      if_q       <= '0;
      ie_q       <= 8'h00;
      ime_q      <= 1'b0;
      ime_pend_q <= 1'b0;
      rdata_q    <= 8'h00;
      hit_q      <= 1'b0;
      vector_q   <= 16'h0000;
    end else begin
      state_q    <= state_d;
      if_q       <= if_d;
      ie_q       <= ie_d;
      ime_q      <= ime_d;
      ime_pend_q <= ime_pend_d;
      rdata_q    <= rdata_d;
      hit_q      <= hit_d;
      vector_q   <= vector_d;
    end
  end

endmodule

// File: tb/tb_gb_interrupt_ctrl.sv
// tb/tb_gb_interrupt_ctrl.sv - table-driven and directed checks for gb_interrupt_ctrl
module tb_gb_interrupt_ctrl;

  localparam logic [15:0] A_IF = 16'hFF0F;
  localparam logic [15:0] A_IE = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  src_pulse;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_we, bus_re;
  logic [7:0]  bus_rdata;
  logic        bus_hit;
  logic        ei_pulse, di_pulse, reti_pulse, instr_done;
  logic        irq_req, irq_ack;
  logic [15:0] irq_vector;
  logic        irq_vec_valid, wake, ime;

  int n_checks = 0;
  int n_fail   = 0;

  gb_interrupt_ctrl dut (
    .clk(clk), .rst_n(rst_n), .src_pulse(src_pulse),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
    .bus_rdata(bus_rdata), .bus_hit(bus_hit),
    .ei_pulse(ei_pulse), .di_pulse(di_pulse), .reti_pulse(reti_pulse), .instr_done(instr_done),
    .irq_req(irq_req), .irq_ack(irq_ack), .irq_vector(irq_vector),
    .irq_vec_valid(irq_vec_valid), .wake(wake), .ime(ime)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [4:0]  src;
    logic        ei;
    logic        di;
    logic        reti;
    logic        idone;
    logic        ack;
    logic [7:0]  e_rdata;
    logic        e_hit;
    logic        e_req;
    logic        e_ime;
    logic        e_wake;
    logic        e_vv;
    logic [15:0] e_vec;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    src_pulse = '0; bus_addr = 16'h0000; bus_wdata = 8'h00; bus_we = 0; bus_re = 0;
    ei_pulse = 0; di_pulse = 0; reti_pulse = 0; instr_done = 0; irq_ack = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_we = 1; bus_addr = a; bus_wdata = d; step();
  endtask

  task automatic rd_check(input string name, input logic [15:0] a, input logic [7:0] exp);
    bus_re = 1; bus_addr = a; step();
    check({name, " rdata"}, {8'h00, bus_rdata}, {8'h00, exp});
    check({name, " hit"}, {15'd0, bus_hit}, 16'd1);
  endtask

  initial begin
    //              we re addr  wd     src    ei di rt id ak  rdata  hit req ime wake vv vec
    tbl[0]  = '{0, 1, A_IF, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'hE0, 1, 0, 0, 0, 0, 16'h0000};
    tbl[1]  = '{0, 1, A_IE, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'h00, 1, 0, 0, 0, 0, 16'h0000};
    tbl[2]  = '{1, 0, A_IE, 8'h1F, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0000};
    tbl[3]  = '{0, 1, A_IE, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'h1F, 1, 0, 0, 0, 0, 16'h0000};
    tbl[4]  = '{0, 0, 16'h0, 8'h00, 5'h00, 0, 0, 1, 0, 0, 8'h00, 0, 0, 1, 0, 0, 16'h0000};
    tbl[5]  = '{0, 0, 16'h0, 8'h00, 5'h14, 0, 0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 0, 16'h0000};
    tbl[6]  = '{0, 0, 16'h0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 1, 0, 16'h0000};
    tbl[7]  = '{0, 0, 16'h0, 8'h00, 5'h00, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 1, 1, 16'h0050};
    tbl[8]  = '{0, 1, A_IF, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'hF0, 1, 0, 0, 1, 0, 16'h0000};
    tbl[9]  = '{1, 0, A_IF, 8'h00, 5'h01, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 16'h0000};
    tbl[10] = '{0, 1, A_IF, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'hE1, 1, 0, 0, 1, 0, 16'h0000};
    tbl[11] = '{1, 0, A_IF, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0000};
    tbl[12] = '{0, 0, 16'h0, 8'h00, 5'h00, 0, 0, 0, 0, 1, 8'h00, 0, 0, 0, 0, 0, 16'h0000};
    tbl[13] = '{1, 0, A_IE, 8'h10, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0000};
    tbl[14] = '{0, 0, 16'h0, 8'h00, 5'h10, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 16'h0000};
    tbl[15] = '{0, 0, 16'h0, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 16'h0000};
    tbl[16] = '{0, 1, A_IF, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'hF0, 1, 0, 0, 1, 0, 16'h0000};
    tbl[17] = '{0, 1, 16'hFF00, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 16'h0000};
    tbl[18] = '{1, 0, A_IF, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0000};
    tbl[19] = '{1, 0, A_IF, 8'h1F, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 1, 0, 16'h0000};
    tbl[20] = '{0, 1, A_IF, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'hFF, 1, 0, 0, 1, 0, 16'h0000};
    tbl[21] = '{1, 0, A_IF, 8'h00, 5'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 16'h0000};

    clear_inputs();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst irq_req", {15'd0, irq_req}, 16'd0);
    check("rst ime", {15'd0, ime}, 16'd0);
    check("rst wake", {15'd0, wake}, 16'd0);
    check("rst vec_valid", {15'd0, irq_vec_valid}, 16'd0);
    check("rst hit", {15'd0, bus_hit}, 16'd0);
    rst_n = 1;

    for (int i = 0; i < 22; i++) begin
      bus_we = tbl[i].we; bus_re = tbl[i].re; bus_addr = tbl[i].addr; bus_wdata = tbl[i].wdata;
      src_pulse = tbl[i].src; ei_pulse = tbl[i].ei; di_pulse = tbl[i].di;
      reti_pulse = tbl[i].reti; instr_done = tbl[i].idone; irq_ack = tbl[i].ack;
      step();
      check($sformatf("v%0d rdata", i), {8'h00, bus_rdata}, {8'h00, tbl[i].e_rdata});
      check($sformatf("v%0d hit", i), {15'd0, bus_hit}, {15'd0, tbl[i].e_hit});
      check($sformatf("v%0d req", i), {15'd0, irq_req}, {15'd0, tbl[i].e_req});
      check($sformatf("v%0d ime", i), {15'd0, ime}, {15'd0, tbl[i].e_ime});
      check($sformatf("v%0d wake", i), {15'd0, wake}, {15'd0, tbl[i].e_wake});
      check($sformatf("v%0d vec_valid", i), {15'd0, irq_vec_valid}, {15'd0, tbl[i].e_vv});
      check($sformatf("v%0d vector", i), irq_vector, tbl[i].e_vec);
    end

    // EI delay: EI with a same-cycle instr_done does not count
    wr(A_IE, 8'h1F);
    ei_pulse = 1; instr_done = 1; step();
    check("ei ime after ei", {15'd0, ime}, 16'd0);
    src_pulse = 5'h04; step();
    check("ei wake", {15'd0, wake}, 16'd1);
    repeat (2) begin
      step();
      check("ei req held off", {15'd0, irq_req}, 16'd0);
      check("ei ime held off", {15'd0, ime}, 16'd0);
    end
    instr_done = 1; step();
    check("ei ime at instr_done", {15'd0, ime}, 16'd1);
    check("ei req same edge", {15'd0, irq_req}, 16'd0);
    step();
    check("ei req rises", {15'd0, irq_req}, 16'd1);
    irq_ack = 1; step();
    check("ei vec_valid", {15'd0, irq_vec_valid}, 16'd1);
    check("ei vector", irq_vector, 16'h0050);
    check("ei ime cleared", {15'd0, ime}, 16'd0);
    rd_check("ei if", A_IF, 8'hE0);

    // Cancel: IE cleared while the CPU is pushing PC
    reti_pulse = 1; src_pulse = 5'h01; step();
    step();
    check("cancel req", {15'd0, irq_req}, 16'd1);
    wr(A_IE, 8'h00);
    check("cancel req held", {15'd0, irq_req}, 16'd1);
    irq_ack = 1; step();
    check("cancel vec_valid", {15'd0, irq_vec_valid}, 16'd1);
    check("cancel vector", irq_vector, 16'h0000);
    check("cancel ime", {15'd0, ime}, 16'd0);
    rd_check("cancel if", A_IF, 8'hE1);

    // IME dropped by DI while in REQ: request withdrawn, IF untouched
    wr(A_IE, 8'h01);
    reti_pulse = 1; step();
    step();
    check("drop req", {15'd0, irq_req}, 16'd1);
    di_pulse = 1; step();
    check("drop ime", {15'd0, ime}, 16'd0);
    step();
    check("drop req gone", {15'd0, irq_req}, 16'd0);
    irq_ack = 1; step();
    check("drop late ack ignored", {15'd0, irq_vec_valid}, 16'd0);
    rd_check("drop if", A_IF, 8'hE1);

    // Reset in the middle of a dispatch
    reti_pulse = 1; step();
    step();
    check("mid req", {15'd0, irq_req}, 16'd1);
    rst_n = 0; step();
    rst_n = 1;
    check("mid rst req", {15'd0, irq_req}, 16'd0);
    check("mid rst ime", {15'd0, ime}, 16'd0);
    check("mid rst wake", {15'd0, wake}, 16'd0);
    rd_check("mid rst if", A_IF, 8'hE0);
    rd_check("mid rst ie", A_IE, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
